uninasoc_irq_router: RTL and testbench

UNINASOC_IRQ_ROUTER -- requirements
Module: uninasoc_irq_router

---
 rtl/uninasoc_pkg.sv | 10 +
 rtl/uninasoc_sync_cell.sv | 18 +
 rtl/uninasoc_irq_router.sv | 85 ++++++++
 tb/tb_uninasoc_irq_router.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uninasoc_pkg.sv
// Shared defaults and types for the UninaSoC interrupt router.
package uninasoc_pkg;
  localparam int NUM_SRC_DEF = 8;
  localparam int SW_PIN_DEF  = 3;
  localparam int TIM_PIN_DEF = 7;
  localparam int EXT_PIN_DEF = 11;
  localparam int CLAIM_W     = $clog2(NUM_SRC_DEF + 1);

  typedef logic [CLAIM_W-1:0] claim_id_t;
endpackage

// File: rtl/uninasoc_sync_cell.sv
// Multi-flop synchroniser for a single asynchronous interrupt line.
module uninasoc_sync_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] r_ff;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_ff <= '0;
    else         r_ff <= {r_ff[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = r_ff[SYNC_STAGES-1];
endmodule

// File: rtl/uninasoc_irq_router.sv
// External interrupt router: synchronise, pend per source, claim/complete gating,
// and fold external/software/timer requests into the core interrupt vector.
module uninasoc_irq_router
  import uninasoc_pkg::*;
#(
  parameter int NUM_SRC     = NUM_SRC_DEF,
  parameter int IRQ_WIDTH   = 32,
  parameter int SW_PIN      = SW_PIN_DEF,
  parameter int TIM_PIN     = TIM_PIN_DEF,
  parameter int EXT_PIN     = EXT_PIN_DEF,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = $clog2(NUM_SRC + 1)
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [NUM_SRC-1:0]   src_i,
  input  logic [NUM_SRC-1:0]   mode_i,
  input  logic [NUM_SRC-1:0]   enable_i,
  input  logic                 sw_irq_i,
  input  logic                 tim_irq_i,
  input  logic                 claim_i,
  output logic [CW-1:0]        claim_id_o,
  input  logic                 complete_i,
  input  logic [CW-1:0]        complete_id_i,
  output logic [NUM_SRC-1:0]   pending_o,
  output logic [IRQ_WIDTH-1:0] irq_o
);
  logic [NUM_SRC-1:0]   w_sync, r_prev, r_pend, r_closed;
  logic [NUM_SRC-1:0]   w_set, w_claim, w_cmp, w_elig, w_edge_ok;
  logic [SYNC_STAGES:0] r_vld;
  logic [CW-1:0]        r_claim_id, w_sel_id;
  logic [IRQ_WIDTH-1:0] r_irq, w_irq_nxt;

  uninasoc_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_SRC-1:0] (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d_i     (src_i),
    .q_o     (w_sync)
  );

  // Edges only count once both the synchroniser and the history flop hold
  // post-reset samples, so a line already high at release never fires.
  assign w_edge_ok = {NUM_SRC{r_vld[SYNC_STAGES]}};

  always_comb begin
    w_elig   = r_pend & enable_i;
    w_sel_id = '0;
    w_claim  = '0;
    w_cmp    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (w_elig[i]) w_sel_id = CW'(i + 1);
    for (int i = 0; i < NUM_SRC; i++) begin
      w_claim[i] = claim_i && (w_sel_id == CW'(i + 1));
      w_cmp[i]   = complete_i && (complete_id_i == CW'(i + 1));
    end
    w_set = ~r_closed & ((mode_i & w_sync & ~r_prev & w_edge_ok) | (~mode_i & w_sync));
    w_irq_nxt          = '0;
    w_irq_nxt[EXT_PIN] = |w_elig;
    w_irq_nxt[SW_PIN]  = sw_irq_i;
    w_irq_nxt[TIM_PIN] = tim_irq_i;
  end

  // Complete applies before claim; a claimed source is never already closed.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_vld      <= '0;
      r_prev     <= '0;
      r_pend     <= '0;
      r_closed   <= '0;
      r_claim_id <= '0;
      r_irq      <= '0;
    end else begin
      r_vld    <= {r_vld[SYNC_STAGES-1:0], 1'b1};
      r_prev   <= w_sync;
      r_pend   <= (r_pend | w_set) & ~w_claim;
      r_closed <= (r_closed & ~w_cmp) | w_claim;
      if (claim_i) r_claim_id <= w_sel_id;
      r_irq    <= w_irq_nxt;
    end
  end

  assign claim_id_o = r_claim_id;
  assign pending_o  = r_pend;
  assign irq_o      = r_irq;
endmodule

// File: tb/tb_uninasoc_irq_router.sv
// Scoreboard bench for uninasoc_irq_router: driver pushes model expectations,
// monitor pops and compares one entry per clock.
module tb_uninasoc_irq_router;
  import uninasoc_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  src = '0, mode = '0, en = '0;
  logic        sw = 1'b0, tim = 1'b0, claim = 1'b0, cmp = 1'b0;
  claim_id_t   cid = '0;
  claim_id_t   claim_id;
  logic [7:0]  pend;
  logic [31:0] irq;

  uninasoc_irq_router dut (
    .clock_i(clk), .reset_i(rst), .src_i(src), .mode_i(mode), .enable_i(en),
    .sw_irq_i(sw), .tim_irq_i(tim), .claim_i(claim), .claim_id_o(claim_id),
    .complete_i(cmp), .complete_id_i(cid), .pending_o(pend), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] pend; logic [31:0] irq; logic [3:0] id;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  // Reference state: raw src samples per clock edge, plus architectural state.
  logic [7:0]  hist[$];
  logic [7:0]  m_pend, m_closed;
  logic [31:0] m_irq;
  logic [3:0]  m_id;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] samp(int j);
    return (j >= 1) ? hist[j] : 8'h00;
  endfunction

  task automatic model_reset();
    hist = {8'h00};
    m_pend = '0; m_closed = '0; m_irq = '0; m_id = '0;
  endtask

  // Called at negedge with inputs settled; models the coming posedge.
  task automatic tick();
    int k, sel;
    logic [7:0] sy, pv, setv, clm;
    hist.push_back(src);
    k = hist.size() - 1;
    sy = samp(k - 2);   // value seen after two synchroniser flops
    pv = samp(k - 3);
    setv = '0; clm = '0; sel = -1;
    for (int i = 0; i < 8; i++) begin
      if (!m_closed[i]) setv[i] = mode[i] ? ((k >= 4) && sy[i] && !pv[i]) : sy[i];
      if (sel < 0 && m_pend[i] && en[i]) sel = i;
    end
    m_irq = '0;
    m_irq[11] = |(m_pend & en);
    m_irq[3]  = sw;
    m_irq[7]  = tim;
    if (cmp && cid >= 1 && cid <= 8) m_closed[cid-1] = 1'b0;
    if (claim) begin
      m_id = (sel < 0) ? 4'd0 : 4'(sel + 1);
      if (sel >= 0) begin clm[sel] = 1'b1; m_closed[sel] = 1'b1; end
    end
    m_pend = (m_pend | setv) & ~clm;
    q.push_back('{m_pend, m_irq, m_id});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(int n, bit c, bit p, int id);
    claim = c; cmp = p; cid = 4'(id);
    tick();
    claim = 1'b0; cmp = 1'b0;
    for (int i = 1; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    run(4, 0, 0, 0);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pending_o", 32'(pend), 32'(e.pend));
      chk("irq_o", irq, e.irq);
      chk("claim_id_o", 32'(claim_id), 32'(e.id));
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_pending", 32'(pend), 32'h0);
    chk("reset_irq", irq, 32'h0);
    chk("reset_claim_id", 32'(claim_id), 32'h0);
    rst = 1'b0;
    mode = 8'hFF; en = 8'hFF;
    run(4, 0, 0, 0);

    // single-cycle edge on source 2, then claim
    src = 8'h04; run(1, 0, 0, 0); src = 8'h00; run(4, 0, 0, 0);
    chk("edge2_pending", 32'(pend), 32'h04);
    chk("edge2_irq_ext", 32'(irq[11]), 32'h1);
    run(2, 1, 0, 0);
    chk("edge2_claim_id", 32'(claim_id), 32'h3);

    // priority: sources 5 and 1, three claims
    do_reset();
    src = 8'h22; run(1, 0, 0, 0); src = 8'h00; run(5, 0, 0, 0);
    run(1, 1, 0, 0); run(1, 1, 0, 0); run(1, 1, 0, 0);
    run(1, 0, 1, 2); run(2, 0, 1, 6);

    // level source 0 re-pends after complete
    do_reset();
    mode = 8'hFE; src = 8'h01; run(5, 0, 0, 0);
    run(3, 1, 0, 0); run(3, 0, 1, 1); src = 8'h00; run(4, 1, 0, 0); run(2, 0, 1, 1);

    // gated edge on source 4, out-of-range complete ignored
    do_reset();
    mode = 8'hFF; src = 8'h10; run(1, 0, 0, 0); src = 8'h00; run(5, 0, 0, 0);
    run(2, 1, 0, 0); src = 8'h10; run(1, 0, 0, 0); src = 8'h00; run(5, 0, 0, 0);
    run(2, 0, 1, 9); run(2, 1, 0, 0); run(1, 0, 1, 5);
    src = 8'h10; run(1, 0, 0, 0); src = 8'h00; run(5, 0, 0, 0);

    // enable masking keeps pending but hides it
    do_reset();
    en = 8'h00; src = 8'h10; run(1, 0, 0, 0); src = 8'h00; run(5, 0, 0, 0);
    run(2, 1, 0, 0); en = 8'h10; run(2, 0, 0, 0); run(2, 1, 0, 0);

    // randomized traffic
    do_reset();
    mode = 8'($urandom); en = 8'hFF;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) src = src ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 19) == 0) en = 8'($urandom);
      sw = 1'($urandom); tim = 1'($urandom);
      claim = ($urandom_range(0, 3) == 0);
      cmp = ($urandom_range(0, 2) == 0);
      cid = 4'($urandom_range(0, 10));
      tick();
    end
    claim = 1'b0; cmp = 1'b0; sw = 1'b0; tim = 1'b0;

    // asynchronous reset with everything pending
    do_reset();
    mode = 8'h00; en = 8'hFF; src = 8'hFF; sw = 1'b1; run(6, 0, 0, 0);
    chk("pre_reset_pending", 32'(pend), 32'hFF);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_pending", 32'(pend), 32'h0);
    chk("async_reset_irq", irq, 32'h0);
    @(negedge clk);
    sw = 1'b0; mode = 8'hFF; model_reset();
    rst = 1'b0;
    // edge sources already high at release must not pend
    run(8, 0, 0, 0);
    chk("no_edge_at_release", 32'(pend), 32'h0);
    src = 8'h00; run(4, 0, 0, 0);

    @(posedge clk); #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
